// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch stage: reset PC, the bubble word,
// instruction field positions and the fetch FSM state type.
package mips_pkg;

   localparam logic [31:0] MIPS_RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUF  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// Single-entry holding register for a fetched word that arrived while IF/ID
// was stalled. Only the full flag is reset; the payload is qualified by it.
module if_skid_buffer
   import mips_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic                  i_clear,
   input  logic [DATA_WIDTH-1:0] i_instr,
   input  logic [DATA_WIDTH-1:0] i_pc_plus4,
   output logic                  o_full,
   output logic [DATA_WIDTH-1:0] o_instr,
   output logic [DATA_WIDTH-1:0] o_pc_plus4
);

   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [DATA_WIDTH-1:0] r_pc_plus4;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
      end
   end

   assign o_full     = r_full;
   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch: PC, imem request/ready handshake, stall skid buffer
// and the IF/ID register; redirects realign the PC and flush IF/ID.
module instruction_fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = MIPS_RESET_PC,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = MIPS_NOP_INSTR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  ifid_valid,
   output logic [DATA_WIDTH-1:0] ifid_instr,
   output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
   output logic [5:0]            ifid_opcode,
   output logic [5:0]            ifid_funct,
   output logic                  pc_misaligned,
   output logic [31:0]           fetch_count
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

   fetch_state_e          r_state;
   logic                  r_imem_req;
   logic [DATA_WIDTH-1:0] r_pc;
   logic                  r_ifid_valid;
   logic [DATA_WIDTH-1:0] r_ifid_instr;
   logic [DATA_WIDTH-1:0] r_ifid_pc_plus4;
   logic                  r_pc_misaligned;
   logic [31:0]           r_fetch_count;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic                  w_skid_load;
   logic                  w_skid_clear;
   logic                  w_skid_full;
   logic [DATA_WIDTH-1:0] w_skid_instr;
   logic [DATA_WIDTH-1:0] w_skid_pc_plus4;

   assign w_pc_plus4 = r_pc + PC_STEP;

   // Redirect discards any response arriving in the same cycle, so it also blocks the skid load.
   assign w_skid_load  = !redirect_valid && (r_state == REQ) && imem_ready && stall;
   assign w_skid_clear = redirect_valid || ((r_state == BUF) && !stall);

   if_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_skid_load),
      .i_clear    (w_skid_clear),
      .i_instr    (imem_rdata),
      .i_pc_plus4 (w_pc_plus4),
      .o_full     (w_skid_full),
      .o_instr    (w_skid_instr),
      .o_pc_plus4 (w_skid_pc_plus4)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_imem_req      <= 1'b0;
         r_pc            <= RESET_PC;
         r_ifid_valid    <= 1'b0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_pc_plus4 <= '0;
         r_pc_misaligned <= 1'b0;
         r_fetch_count   <= 32'd0;
      end else begin
         r_pc_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            r_state         <= REQ;
            r_imem_req      <= 1'b1;
            r_pc            <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state    <= REQ;
                  r_imem_req <= 1'b1;
               end
               REQ: begin
                  if (imem_ready && !stall) begin
                     r_ifid_valid    <= 1'b1;
                     r_ifid_instr    <= imem_rdata;
                     r_ifid_pc_plus4 <= w_pc_plus4;
                     r_pc            <= w_pc_plus4;
                     r_fetch_count   <= r_fetch_count + 32'd1;
                  end else if (imem_ready) begin
                     r_state    <= BUF;
                     r_imem_req <= 1'b0;
                  end else if (!stall) begin
                     r_ifid_valid <= 1'b0;
                     r_ifid_instr <= NOP_INSTR;
                  end
               end
               BUF: begin
                  if (!stall && w_skid_full) begin
                     r_ifid_valid    <= 1'b1;
                     r_ifid_instr    <= w_skid_instr;
                     r_ifid_pc_plus4 <= w_skid_pc_plus4;
                     r_pc            <= w_skid_pc_plus4;
                     r_fetch_count   <= r_fetch_count + 32'd1;
                     r_state         <= REQ;
                     r_imem_req      <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= IDLE;
                  r_imem_req <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imem_req      = r_imem_req;
   assign imem_addr     = r_pc;
   assign ifid_valid    = r_ifid_valid;
   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc_plus4 = r_ifid_pc_plus4;
   assign ifid_opcode   = r_ifid_instr[OPCODE_MSB:OPCODE_LSB];
   assign ifid_funct    = r_ifid_instr[FUNCT_MSB:FUNCT_LSB];
   assign pc_misaligned = r_pc_misaligned;
   assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: streaming, bubbles, stall skid,
// redirects, misalignment, PC wrap and reset during a stall.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic [5:0]  ifid_opcode;
   logic [5:0]  ifid_funct;
   logic        pc_misaligned;
   logic [31:0] fetch_count;

   int checks;
   int failures;

   logic [31:0] words [4];

   instruction_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_opcode    (ifid_opcode),
      .ifid_funct     (ifid_funct),
      .pc_misaligned  (pc_misaligned),
      .fetch_count    (fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL reset_addr got=%h exp=00400000", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
      checks++; if (ifid_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc_plus4); end
      checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      checks++; if (pc_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misal got=%b exp=0", pc_misaligned); end
   endtask

   task automatic test_stream();
      reset = 1'b0; imem_ready = 1'b1;
      tick();
      // IDLE -> REQ on the first cycle out of reset
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req got=%b exp=1", imem_req); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_addr !== 32'h0040_0000 + 32'(4*i)) begin failures++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, 32'h0040_0000 + 32'(4*i)); end
         imem_rdata = words[i];
         tick();
         checks++; if (ifid_valid !== 1'b1 || ifid_instr !== words[i]) begin failures++; $display("FAIL stream_instr%0d got=%b/%h exp=1/%h", i, ifid_valid, ifid_instr, words[i]); end
         checks++; if (ifid_pc_plus4 !== 32'h0040_0004 + 32'(4*i)) begin failures++; $display("FAIL stream_pc4_%0d got=%h exp=%h", i, ifid_pc_plus4, 32'h0040_0004 + 32'(4*i)); end
      end
      checks++; if (ifid_opcode !== 6'h2B || ifid_funct !== 6'h08) begin failures++; $display("FAIL stream_fields got=%h/%h exp=2b/08", ifid_opcode, ifid_funct); end
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL stream_count got=%0d exp=4", fetch_count); end
   endtask

   task automatic test_not_ready();
      // Redirect to 0x00400004 with a same-cycle response that must be dropped
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0004; imem_rdata = 32'hCAFE_F00D;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL redir_discard_count got=%0d exp=4", fetch_count); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL redir_flush got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
      imem_rdata = words[1];
      tick();
      checks++; if (imem_addr !== 32'h0040_0008 || ifid_instr !== words[1]) begin failures++; $display("FAIL nr_setup got=%h/%h exp=00400008/%h", imem_addr, ifid_instr, words[1]); end
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL nr_bubble%0d got=%b/%h exp=0/0", i, ifid_valid, ifid_instr); end
         checks++; if (imem_addr !== 32'h0040_0008 || ifid_pc_plus4 !== 32'h0040_0008) begin failures++; $display("FAIL nr_hold%0d got=%h/%h exp=00400008/00400008", i, imem_addr, ifid_pc_plus4); end
      end
      imem_ready = 1'b1; imem_rdata = words[2];
      tick();
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== words[2] || ifid_pc_plus4 !== 32'h0040_000C) begin failures++; $display("FAIL nr_resume got=%b/%h/%h exp=1/%h/0040000c", ifid_valid, ifid_instr, ifid_pc_plus4, words[2]); end
      checks++; if (fetch_count !== 32'd6) begin failures++; $display("FAIL nr_count got=%0d exp=6", fetch_count); end
   endtask

   task automatic test_stall_buf();
      imem_rdata = 32'h2008_0005; stall = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b0 || ifid_instr !== words[2]) begin failures++; $display("FAIL buf_enter got=%b/%h exp=0/%h", imem_req, ifid_instr, words[2]); end
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (imem_req !== 1'b0 || ifid_instr !== words[2] || imem_addr !== 32'h0040_000C) begin failures++; $display("FAIL buf_hold got=%b/%h/%h exp=0/%h/0040000c", imem_req, ifid_instr, imem_addr, words[2]); end
      stall = 1'b0;
      tick();
      checks++; if (ifid_instr !== 32'h2008_0005 || ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h0040_0010) begin failures++; $display("FAIL buf_drain got=%b/%h/%h exp=1/20080005/00400010", ifid_valid, ifid_instr, ifid_pc_plus4); end
      checks++; if (imem_addr !== 32'h0040_0010 || imem_req !== 1'b1 || fetch_count !== 32'd7) begin failures++; $display("FAIL buf_advance got=%h/%b/%0d exp=00400010/1/7", imem_addr, imem_req, fetch_count); end
   endtask

   task automatic test_redirect_buf();
      imem_ready = 1'b1; imem_rdata = words[3]; stall = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rb_enter got=%b exp=0", imem_req); end
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'h0040_0100 || imem_req !== 1'b1) begin failures++; $display("FAIL rb_pc got=%h/%b exp=00400100/1", imem_addr, imem_req); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rb_flush got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_instr, ifid_pc_plus4); end
      checks++; if (fetch_count !== 32'd7 || pc_misaligned !== 1'b0) begin failures++; $display("FAIL rb_count got=%0d/%b exp=7/0", fetch_count, pc_misaligned); end
      stall = 1'b0;
      tick();
      checks++; if (ifid_valid !== 1'b0 || fetch_count !== 32'd7) begin failures++; $display("FAIL rb_empty got=%b/%0d exp=0/7", ifid_valid, fetch_count); end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'h0040_0100 || pc_misaligned !== 1'b1) begin failures++; $display("FAIL misal_pulse got=%h/%b exp=00400100/1", imem_addr, pc_misaligned); end
      tick();
      checks++; if (pc_misaligned !== 1'b0) begin failures++; $display("FAIL misal_clear got=%b exp=0", pc_misaligned); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", imem_addr); end
      imem_ready = 1'b1; imem_rdata = words[1];
      tick();
      checks++; if (ifid_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || ifid_instr !== words[1]) begin failures++; $display("FAIL wrap_pc4 got=%h/%h/%h exp=0/0/%h", ifid_pc_plus4, imem_addr, ifid_instr, words[1]); end
      checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", fetch_count); end
   endtask

   task automatic test_reset_mid_stall();
      imem_rdata = words[2]; stall = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rs_buf got=%b exp=0", imem_req); end
      reset = 1'b1;
      tick();
      checks++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL rs_ctrl got=%h/%b/%b exp=00400000/0/0", imem_addr, imem_req, ifid_valid); end
      checks++; if (ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0 || fetch_count !== 32'd0 || pc_misaligned !== 1'b0) begin failures++; $display("FAIL rs_data got=%h/%h/%0d/%b exp=0/0/0/0", ifid_instr, ifid_pc_plus4, fetch_count, pc_misaligned); end
      reset = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL rs_restart got=%b/%h exp=1/00400000", imem_req, imem_addr); end
      tick();
      checks++; if (ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin failures++; $display("FAIL rs_dropped got=%b/%0d exp=0/0", ifid_valid, fetch_count); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      words[0] = 32'h2008_0005;
      words[1] = 32'h0109_5020;
      words[2] = 32'h8D0A_0004;
      words[3] = 32'hAD0A_0008;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      test_reset();
      test_stream();
      test_not_ready();
      test_stall_buf();
      test_redirect_buf();
      test_misaligned();
      test_wrap();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage of the MIPS datapath, directly upstream of the control unit.
- Holds the PC and drives the instruction-memory request/ready handshake.
- Buffers a returned word while the pipeline is stalled, and loads the IF/ID register.
- Exposes ifid_opcode/ifid_funct, which feed the control unit's OP/Function inputs. Taken branches and jumps redirect the PC and flush IF/ID.

Parameters:
- DATA_WIDTH, 32, instruction/PC width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  downstream hazard: IF/ID must hold.
- redirect_valid  input  1  taken branch/jump/jal this cycle.
- redirect_pc  input  32  target PC.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word address (= PC).
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  input  32  fetched instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc_plus4  output  32  PC+4 of that instruction.
- ifid_opcode  output  6  ifid_instr[31:26], combinational.
- ifid_funct  output  6  ifid_instr[5:0], combinational.
- pc_misaligned  output  1  one-cycle pulse when redirect_pc[1:0] != 0.
- fetch_count  output  32  instructions delivered to IF/ID.

Behaviour:
- Reset values: PC=RESET_PC, state=IDLE, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, pc_misaligned=0, fetch_count=0, skid buffer empty. Reset overrides every other input.
- imem_addr = PC at all times.
- imem_req = 1 in REQ, 0 in IDLE and BUF.
- FSM IDLE: go to REQ next cycle unconditionally.
- FSM REQ, imem_ready=1, stall=0: IF/ID <= {valid=1, imem_rdata, PC+4}; PC <= PC+4; fetch_count++; stay in REQ.
- FSM REQ, imem_ready=1, stall=1: skid <= {imem_rdata, PC+4}; IF/ID holds; PC unchanged; go to BUF.
- FSM REQ, imem_ready=0, stall=0: IF/ID <= {valid=0, NOP_INSTR, ifid_pc_plus4 held}. This inserts a bubble.
- FSM REQ, imem_ready=0, stall=1: IF/ID holds.
- FSM BUF, stall=1: hold everything.
- FSM BUF, stall=0: IF/ID <= skid (valid=1); PC <= skid PC+4; fetch_count++; go to REQ.
- Latency: a word sampled with imem_ready appears on ifid_* the next cycle when unstalled. Sustained throughput is 1 instruction/cycle when imem_ready stays high.
- Redirect priority: reset > redirect_valid > stall.
- On redirect_valid: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= {0, NOP_INSTR, 0}; skid cleared; state <= REQ. An imem_ready response in the same cycle is discarded and fetch_count does not increment. Redirect overrides stall, because a flush is always allowed.
- pc_misaligned is asserted the cycle after a redirect with redirect_pc[1:0] != 0.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_count wraps modulo 2^32.
- imem_ready is ignored outside REQ.
- Reset mid-BUF or mid-request drops the buffered word and the pending request.

Decomposition:
- mips_pkg: NOP_INSTR, RESET_PC default, fetch state enum {IDLE, REQ, BUF}, opcode/funct bit-field positions.
- One sub-module, if_skid_buffer: single-entry {instr, pc_plus4} register with load/clear/full. The FSM, PC and IF/ID register stay in the top.

Test Plan:
- Reset, then imem_ready=1 every cycle, words W0..W3 -> imem_addr 0x00400000,04,08,0C on consecutive cycles; ifid_instr=W0 with ifid_pc_plus4=0x00400004 at cycle 2 after IDLE; fetch_count=4 after 4 deliveries.
- imem_ready low 3 cycles at PC 0x00400008 -> ifid_valid=0 and ifid_instr=0 for those cycles; PC stays 0x00400008; resumes on ready.
- Ready with word 0x2008_0005 while stall=1 for 2 cycles -> IF/ID unchanged, state BUF, imem_req=0; stall drops -> ifid_instr=0x2008_0005, PC advances by 4.
- redirect_valid with redirect_pc=0x0040_0100 while in BUF and stall=1 -> next cycle PC=0x0040_0100, ifid_valid=0, skid empty, fetch_count unchanged.
- redirect_pc=0x0040_0102 -> PC=0x0040_0100, pc_misaligned pulses one cycle.
- Redirect to 0xFFFF_FFFC, ready=1 -> ifid_pc_plus4=0, next imem_addr=0. Reset asserted mid-stall -> all outputs return to reset values next cycle.
